// File: rtl/if_stage_fetch.sv
// rtl/if_stage_fetch.sv - RISC-V IF stage: PC, imem request handshake, IF/ID register
// Optional performance counters are enabled by defining IF_STAGE_PERF_CNT_EN.
module if_stage_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_write,
   input  logic        flush,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid
`ifdef IF_STAGE_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_discard_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n, pc_inc;
   logic [31:0] addr_n;
   logic [31:0] hold_buf, hold_buf_n;
   logic [31:0] if_id_pc_n, if_id_instr_n;
   logic        if_id_valid_n;

   assign pc_inc   = pc + 32'd4;
   assign imem_req = (state == FETCH) || (state == DISCARD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         imem_addr   <= RESET_PC;
         hold_buf    <= 32'd0;
         if_id_pc    <= 32'd0;
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         imem_addr   <= addr_n;
         hold_buf    <= hold_buf_n;
         if_id_pc    <= if_id_pc_n;
         if_id_instr <= if_id_instr_n;
         if_id_valid <= if_id_valid_n;
      end
   end

   always_comb begin
      state_n       = state;
      pc_n          = pc;
      addr_n        = imem_addr;
      hold_buf_n    = hold_buf;
      if_id_pc_n    = if_id_pc;
      if_id_instr_n = if_id_instr;
      if_id_valid_n = if_id_valid;
      if (flush) begin
         // An outstanding request cannot be cancelled; DISCARD swallows its response.
         if_id_valid_n = 1'b0;
         if_id_instr_n = NOP_INSTR;
         pc_n          = branch_target;
         if (imem_req && !imem_ready) begin
            state_n = DISCARD;
         end else begin
            state_n = FETCH;
            addr_n  = branch_target;
         end
      end else begin
         case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
               if (imem_ready) begin
                  if (pc_write) begin
                     if_id_pc_n    = pc;
                     if_id_instr_n = imem_rdata;
                     if_id_valid_n = 1'b1;
                     pc_n          = pc_inc;
                     addr_n        = pc_inc;
                  end else begin
                     hold_buf_n = imem_rdata;
                     state_n    = HOLD;
                  end
               end else if (pc_write) begin
                  if_id_pc_n    = pc;
                  if_id_instr_n = NOP_INSTR;
                  if_id_valid_n = 1'b0;
               end
            end
            HOLD: begin
               if (pc_write) begin
                  if_id_pc_n    = pc;
                  if_id_instr_n = hold_buf;
                  if_id_valid_n = 1'b1;
                  pc_n          = pc_inc;
                  addr_n        = pc_inc;
                  state_n       = FETCH;
               end
            end
            DISCARD: begin
               if (imem_ready) begin
                  addr_n  = pc;
                  state_n = FETCH;
               end else if (pc_write) begin
                  if_id_pc_n    = pc;
                  if_id_instr_n = NOP_INSTR;
                  if_id_valid_n = 1'b0;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

`ifdef IF_STAGE_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt   <= 32'd0;
         perf_discard_cnt <= 32'd0;
      end else begin
         if (!pc_write && !flush)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (state == DISCARD && state_n == FETCH)
            perf_discard_cnt <= perf_discard_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_stage_fetch.sv
// tb/tb_if_stage_fetch.sv - scoreboard bench for if_stage_fetch
module tb_if_stage_fetch;

   typedef struct {
      int          cyc;
      logic        req;
      logic [31:0] addr;
      logic [31:0] ifpc;
      logic [31:0] instr;
      logic        valid;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_write = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] branch_target = 32'd0;
   logic        imem_ready = 1'b0;
   logic        imem_req, u1_req;
   logic [31:0] imem_addr, imem_rdata, if_id_pc, if_id_instr;
   logic [31:0] u1_addr, u1_rdata, u1_ifpc, u1_instr;
   logic        if_id_valid, u1_valid;
`ifdef IF_STAGE_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_discard_cnt, u1_stall, u1_disc;
`endif

   exp_t        q[$];
   logic [31:0] q1[$];
   int          total = 0;
   int          bad = 0;
   int          cycn = 0;

   always #5 clk = ~clk;

   assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
   assign u1_rdata   = u1_addr ^ 32'hA5A5_0000;

   if_stage_fetch dut (
      .clk(clk), .rst(rst), .pc_write(pc_write), .flush(flush),
      .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ready(imem_ready), .if_id_pc(if_id_pc),
      .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
`ifdef IF_STAGE_PERF_CNT_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_discard_cnt(perf_discard_cnt)
`endif
   );

   if_stage_fetch #(.RESET_PC(32'hFFFF_FFF8)) u1 (
      .clk(clk), .rst(rst), .pc_write(1'b1), .flush(1'b0),
      .branch_target(32'd0), .imem_req(u1_req), .imem_addr(u1_addr),
      .imem_rdata(u1_rdata), .imem_ready(1'b1), .if_id_pc(u1_ifpc),
      .if_id_instr(u1_instr), .if_id_valid(u1_valid)
`ifdef IF_STAGE_PERF_CNT_EN
      , .perf_stall_cnt(u1_stall), .perf_discard_cnt(u1_disc)
`endif
   );

   task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, req);
      end
   endtask

   // Monitor: pops one expectation per cycle after each active edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("imem_req", e.cyc, {31'd0, imem_req}, {31'd0, e.req});
            chk("imem_addr", e.cyc, imem_addr, e.addr);
            chk("if_id_pc", e.cyc, if_id_pc, e.ifpc);
            chk("if_id_instr", e.cyc, if_id_instr, e.instr);
            chk("if_id_valid", e.cyc, {31'd0, if_id_valid}, {31'd0, e.valid});
         end
         if (u1_req && q1.size() > 0)
            chk("wrap_addr", cycn, u1_addr, q1.pop_front());
      end
   end

   task automatic cyc(input logic pw, input logic fl, input logic [31:0] tgt, input logic rdy,
                      input logic ereq, input logic [31:0] eaddr, input logic [31:0] epc,
                      input logic [31:0] einstr, input logic evalid);
      exp_t e;
      pc_write      = pw;
      flush         = fl;
      branch_target = tgt;
      imem_ready    = rdy;
      e.cyc = cycn; e.req = ereq; e.addr = eaddr; e.ifpc = epc; e.instr = einstr; e.valid = evalid;
      q.push_back(e);
      cycn++;
      @(negedge clk);
   endtask

   initial begin
      q1.push_back(32'hFFFF_FFF8);
      q1.push_back(32'hFFFF_FFFC);
      q1.push_back(32'h0000_0000);
      @(negedge clk);
      //   pw fl tgt       rdy  req addr       ifpc      instr          v
      cyc(1, 0, 32'h0,   1,   0, 32'h0,     32'h0,    32'h13,        0);
      rst = 1'b0;
      cyc(1, 0, 32'h0,   1,   1, 32'h0,     32'h0,    32'h13,        0);
      cyc(1, 0, 32'h0,   1,   1, 32'h4,     32'h0,    32'hA5A5_0000, 1);
      cyc(1, 0, 32'h0,   1,   1, 32'h8,     32'h4,    32'hA5A5_0004, 1);
      // stall during a completed fetch at pc 8
      cyc(0, 0, 32'h0,   1,   0, 32'h8,     32'h4,    32'hA5A5_0004, 1);
      cyc(0, 0, 32'h0,   1,   0, 32'h8,     32'h4,    32'hA5A5_0004, 1);
      cyc(0, 0, 32'h0,   1,   0, 32'h8,     32'h4,    32'hA5A5_0004, 1);
      cyc(1, 0, 32'h0,   1,   1, 32'hC,     32'h8,    32'hA5A5_0008, 1);
      // redirect while the fetch at pc 12 is outstanding
      cyc(1, 1, 32'h100, 0,   1, 32'hC,     32'h8,    32'h13,        0);
      cyc(1, 0, 32'h0,   0,   1, 32'hC,     32'h100,  32'h13,        0);
      cyc(1, 0, 32'h0,   1,   1, 32'h100,   32'h100,  32'h13,        0);
      cyc(1, 0, 32'h0,   1,   1, 32'h104,   32'h100,  32'hA5A5_0100, 1);
      // flush wins over a simultaneous stall
      cyc(0, 1, 32'h200, 1,   1, 32'h200,   32'h100,  32'h13,        0);
      // memory wait states produce bubbles
      cyc(1, 0, 32'h0,   0,   1, 32'h200,   32'h200,  32'h13,        0);
      cyc(1, 0, 32'h0,   0,   1, 32'h200,   32'h200,  32'h13,        0);
      cyc(1, 0, 32'h0,   1,   1, 32'h204,   32'h200,  32'hA5A5_0200, 1);
      cyc(0, 0, 32'h0,   0,   1, 32'h204,   32'h200,  32'hA5A5_0200, 1);
      cyc(1, 0, 32'h0,   1,   1, 32'h208,   32'h204,  32'hA5A5_0204, 1);
      // flush out of HOLD
      cyc(0, 0, 32'h0,   1,   0, 32'h208,   32'h204,  32'hA5A5_0204, 1);
      cyc(0, 1, 32'h300, 1,   1, 32'h300,   32'h204,  32'h13,        0);
      cyc(1, 0, 32'h0,   1,   1, 32'h304,   32'h300,  32'hA5A5_0300, 1);

      for (int i = 0; i < 20 && (q.size() > 0 || q1.size() > 0); i++)
         @(negedge clk);
      total++;
      if (q.size() != 0 || q1.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d/%0d pending expected 0/0", q.size(), q1.size());
      end
`ifdef IF_STAGE_PERF_CNT_EN
      chk("perf_stall_cnt", cycn, perf_stall_cnt, 32'd5);
      chk("perf_discard_cnt", cycn, perf_discard_cnt, 32'd1);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_stage_fetch.md
Name: if_stage_fetch

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Consumes the stall enable from the hazard detection unit (pc_write) and the redirect from EX (flush, branch_target).
- Produces the IF/ID contents consumed by decode and by the hazard unit's operand-address compare.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on a bubble or flush (addi x0,x0,0).

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  reset.
- pc_write  input  1  1 = pipeline advances; 0 = hazard stall, hold PC and IF/ID.
- flush  input  1  taken branch/jump redirect from EX.
- branch_target  input  32  redirect address, sampled when flush=1.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address, stable while imem_req=1 and imem_ready=0.
- imem_rdata  input  32  instruction, valid when imem_req & imem_ready.
- imem_ready  input  1  memory completes the request this cycle.
- if_id_pc  output  32  PC of the instruction in IF/ID.
- if_id_instr  output  32  instruction in IF/ID.
- if_id_valid  output  1  IF/ID holds a real instruction.

Interface rule: one clock, clk; reset rst is asynchronous and active-high.

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, hold buffer=0.
- States: IDLE, FETCH, HOLD, DISCARD.
- imem_req=1 in FETCH and DISCARD, 0 otherwise.
- In FETCH, imem_addr==pc. In DISCARD, imem_addr keeps the stale outstanding address while pc holds the new target.
- "word available" means (FETCH & imem_ready) or HOLD. The word is imem_rdata in FETCH, the hold buffer in HOLD.

Transitions and actions:
- IDLE: next cycle goes to FETCH. Reset deassert to first imem_req is 1 cycle.
- Any state, flush=1 (highest priority):
  - if_id_valid<=0, if_id_instr<=NOP_INSTR, pc<=branch_target.
  - FETCH with ready=0, or DISCARD with ready=0: go to DISCARD.
  - FETCH with ready=1, HOLD, or DISCARD with ready=1: go to FETCH, imem_addr<=branch_target.
  - flush overrides pc_write=0.
- FETCH, ready=1, pc_write=1: IF/ID<={pc, imem_rdata, 1}; pc and imem_addr <= pc+4; stay FETCH.
- FETCH, ready=1, pc_write=0: buffer imem_rdata; pc unchanged; IF/ID unchanged; go to HOLD.
- FETCH, ready=0, pc_write=1: IF/ID<={pc, NOP_INSTR, 0} (bubble).
- FETCH, ready=0, pc_write=0: IF/ID holds.
- HOLD, pc_write=1: IF/ID<={pc, buffer, 1}; pc and imem_addr <= pc+4; go to FETCH.
- HOLD, pc_write=0: no change.
- DISCARD, ready=1: drop imem_rdata; imem_addr<=pc; go to FETCH.
- DISCARD, ready=0: if pc_write=1, insert a bubble.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. Target bits [1:0] pass through unmodified.
- With imem_ready tied 1 and no stalls: one instruction per cycle; IF/ID valid 2 cycles after reset deassert.
- An async reset mid-request returns to IDLE immediately; the pending memory response is ignored.

Optional Feature:
- Macro: IF_STAGE_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_discard_cnt[31:0], both reset to 0.
  - perf_stall_cnt increments each cycle with pc_write=0 and flush=0.
  - perf_discard_cnt increments on each DISCARD-to-FETCH transition.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem_ready=1, rdata=addr^32'hA5A5_0000, 4 cycles -> IF/ID shows pc 0,4,8 with matching instructions, valid=1 from the 2nd cycle.
- pc_write=0 for 3 cycles during a ready=1 fetch at pc 8 -> HOLD entered; IF/ID frozen at pc 4; on release, IF/ID pc=8 with the buffered word; the next imem_addr is 12.
- flush=1, branch_target=32'h100 while imem_ready=0 at pc 12 -> DISCARD; the next ready's data is dropped; the following request has imem_addr=32'h100; IF/ID valid=0 in between.
- flush and pc_write=0 in the same cycle -> if_id_valid=0, if_id_instr=32'h13, pc=branch_target.
- RESET_PC=32'hFFFF_FFF8, ready=1 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- imem_ready low for 2 cycles with pc_write=1 -> two bubbles (valid=0, NOP) and imem_addr stable; with IF_STAGE_PERF_CNT_EN defined, perf_discard_cnt=1 after the third scenario.
